// File: rtl/axi4_lite_reg_bridge_if.sv
// AXI4-Lite channel bundle between the AXI bus FIFO stage and slaves.
// Slave modport takes AW/W/AR in and drives B/R out.
interface axi4_lite_if #(
    parameter int A = 32,
    parameter int N = 4
);
    logic           awvalid;
    logic           awready;
    logic [A-1:0]   awaddr;
    logic [2:0]     awprot;
    logic           wvalid;
    logic           wready;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           bvalid;
    logic           bready;
    logic [1:0]     bresp;
    logic           arvalid;
    logic           arready;
    logic [A-1:0]   araddr;
    logic [2:0]     arprot;
    logic           rvalid;
    logic           rready;
    logic [1:0]     rresp;
    logic [8*N-1:0] rdata;

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rresp, rdata
    );

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave to single-access register bus bridge.
// One transaction in flight, alternating arbitration, access timeout.
module axi4_lite_reg_bridge #(
    parameter int A       = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           aclk,
    input  logic           areset,
    axi4_lite_if.slave     axi4_s,
    output logic [A-1:0]   reg_addr,
    output logic           reg_wr,
    output logic           reg_rd,
    output logic [8*N-1:0] reg_wdata,
    output logic [N-1:0]   reg_wstrb,
    input  logic [8*N-1:0] reg_rdata,
    input  logic           reg_ready,
    input  logic           reg_err
);
    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        RD_ACC,
        B_RESP,
        R_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t         state;
    logic [7:0]     cnt;
    logic           last_wr;
    logic           bvalid_q;
    logic           rvalid_q;
    logic [1:0]     bresp_q;
    logic [1:0]     rresp_q;
    logic [8*N-1:0] rdata_q;

    logic wr_pend;
    logic rd_pend;
    logic is_idle;
    logic grant_wr;
    logic grant_rd;
    logic unused_prot;

    // Grant decision: on contention serve the side not granted last
    always_comb begin
        wr_pend  = axi4_s.awvalid & axi4_s.wvalid;
        rd_pend  = axi4_s.arvalid;
        is_idle  = (state == IDLE);
        grant_wr = is_idle & wr_pend & (~rd_pend | ~last_wr);
        grant_rd = is_idle & rd_pend & (~wr_pend | last_wr);
    end

    assign axi4_s.awready = grant_wr;
    assign axi4_s.wready  = grant_wr;
    assign axi4_s.arready = grant_rd;
    assign axi4_s.bvalid  = bvalid_q;
    assign axi4_s.bresp   = bresp_q;
    assign axi4_s.rvalid  = rvalid_q;
    assign axi4_s.rresp   = rresp_q;
    assign axi4_s.rdata   = rdata_q;

    // Protection bits carry no meaning for the register bus
    assign unused_prot = ^{axi4_s.awprot, axi4_s.arprot};

    // Transaction sequencer: grant, register access, AXI response
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_wr   <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        reg_addr  <= axi4_s.awaddr;
                        reg_wdata <= axi4_s.wdata;
                        reg_wstrb <= axi4_s.wstrb;
                        reg_wr    <= 1'b1;
                        cnt       <= '0;
                        last_wr   <= 1'b1;
                        state     <= WR_ACC;
                    end else if (grant_rd) begin
                        reg_addr <= axi4_s.araddr;
                        reg_rd   <= 1'b1;
                        cnt      <= '0;
                        last_wr  <= 1'b0;
                        state    <= RD_ACC;
                    end
                end
                WR_ACC: begin
                    if (reg_ready) begin
                        bresp_q  <= reg_err ? 2'b10 : 2'b00;
                        reg_wr   <= 1'b0;
                        bvalid_q <= 1'b1;
                        state    <= B_RESP;
                    end else if (cnt == CNT_LAST) begin
                        bresp_q  <= 2'b11;
                        reg_wr   <= 1'b0;
                        bvalid_q <= 1'b1;
                        state    <= B_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_ACC: begin
                    if (reg_ready) begin
                        rresp_q  <= reg_err ? 2'b10 : 2'b00;
                        rdata_q  <= reg_rdata;
                        reg_rd   <= 1'b0;
                        rvalid_q <= 1'b1;
                        state    <= R_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rresp_q  <= 2'b11;
                        rdata_q  <= '0;
                        reg_rd   <= 1'b0;
                        rvalid_q <= 1'b1;
                        state    <= R_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                B_RESP: begin
                    if (axi4_s.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                R_RESP: begin
                    if (axi4_s.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Self-checking bench for axi4_lite_reg_bridge.
// Vector table, directed corner sequences, randomized traffic vs model.
module tb_axi4_lite_reg_bridge;
    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        reg_err;

    always #5 aclk = ~aclk;

    axi4_lite_if #(.A(32), .N(4)) axi ();

    axi4_lite_reg_bridge #(.A(32), .N(4), .TIMEOUT(16)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .axi4_s    (axi),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .reg_err   (reg_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake expected one within bound", name);
    endtask

    // Register target: answers after tgt_wait strobe cycles, 16 words
    int          tgt_wait = 0;
    bit          tgt_err = 1'b0;
    logic [31:0] tgt_mem [16];
    int          last_len = 0;
    int          n_acc = 0;

    initial begin
        int acc;
        acc = 0;
        for (int i = 0; i < 16; i++) tgt_mem[i] = 32'h1000_0000 + i;
        tgt_mem[9] = 32'h1234_5678;
        reg_ready = 1'b0;
        reg_err   = 1'b0;
        reg_rdata = '0;
        forever begin
            @(posedge aclk);
            #2;
            if (reg_wr || reg_rd) begin
                if (acc == 0) n_acc++;
                if (acc == tgt_wait) begin
                    reg_ready = 1'b1;
                    reg_err   = tgt_err;
                    reg_rdata = tgt_mem[reg_addr[5:2]];
                    if (reg_wr && !tgt_err)
                        for (int b = 0; b < 4; b++)
                            if (reg_wstrb[b])
                                tgt_mem[reg_addr[5:2]][8*b +: 8] =
                                    reg_wdata[8*b +: 8];
                end else begin
                    reg_ready = 1'b0;
                    reg_err   = 1'($urandom_range(0, 1));
                    reg_rdata = $urandom;
                end
                acc++;
            end else begin
                if (acc > 0) last_len = acc;
                acc       = 0;
                reg_ready = 1'b0;
                reg_err   = 1'b0;
            end
        end
    end

    // Reference memory: what a correct bridge leaves in the target
    logic [31:0] ref_mem [16];

    function automatic void ref_write(input logic [31:0] addr,
                                      input logic [31:0] data,
                                      input logic [3:0]  strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic finish_write(input int bp, output logic [1:0] resp,
                                output int lat);
        int n;
        int bad;
        n = 0;
        #2;
        while (!(axi.awready && axi.wready) && n < 40) begin
            @(posedge aclk);
            #3;
            n++;
        end
        if (n >= 40) begin
            bound_fail("aw_w_handshake");
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
            resp = 2'bxx;
            lat  = -1;
            tick();
            return;
        end
        @(posedge aclk);
        #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = (bp == 0);
        lat = 1;
        #2;
        while (!axi.bvalid && lat < 40) begin
            @(posedge aclk);
            #3;
            lat++;
        end
        if (!axi.bvalid) begin
            bound_fail("bvalid_wait");
            axi.bready = 1'b1;
            resp = 2'bxx;
            tick();
            return;
        end
        resp = axi.bresp;
        if (bp > 0) begin
            bad = 0;
            for (int c = 0; c < bp; c++) begin
                @(posedge aclk);
                #3;
                if (!axi.bvalid || axi.bresp !== resp || axi.arready ||
                    axi.awready || reg_rd || reg_wr)
                    bad++;
            end
            chk("b_backpressure_stable", bad, 0);
            @(posedge aclk);
            #1;
            axi.bready = 1'b1;
            #2;
            chk("no_grant_in_b_handshake",
                {30'b0, axi.bvalid, axi.arready}, 32'h2);
        end
        tick();
    endtask

    task automatic finish_read(output logic [1:0] resp,
                               output logic [31:0] data, output int lat);
        int n;
        n = 0;
        #2;
        while (!axi.arready && n < 40) begin
            @(posedge aclk);
            #3;
            n++;
        end
        if (n >= 40) begin
            bound_fail("ar_handshake");
            axi.arvalid = 1'b0;
            resp = 2'bxx;
            data = 'x;
            lat  = -1;
            tick();
            return;
        end
        @(posedge aclk);
        #1;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        lat = 1;
        #2;
        while (!axi.rvalid && lat < 40) begin
            @(posedge aclk);
            #3;
            lat++;
        end
        if (!axi.rvalid) begin
            bound_fail("rvalid_wait");
            resp = 2'bxx;
            data = 'x;
            tick();
            return;
        end
        resp = axi.rresp;
        data = axi.rdata;
        tick();
    endtask

    task automatic run_txn(input string tag, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int wt,
                           input bit err, input logic [1:0] eresp,
                           input logic [31:0] erdata, input int elen,
                           input int elat);
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        int          n0;
        n0 = n_acc;
        tgt_wait = wt;
        tgt_err  = err;
        if (wr) begin
            axi.awaddr  = addr;
            axi.wdata   = data;
            axi.wstrb   = strb;
            axi.awvalid = 1'b1;
            axi.wvalid  = 1'b1;
            finish_write(0, resp, lat);
        end else begin
            axi.araddr  = addr;
            axi.arvalid = 1'b1;
            finish_read(resp, rd, lat);
            chk($sformatf("%s_rdata", tag), rd, erdata);
        end
        chk($sformatf("%s_resp", tag), {30'b0, resp}, {30'b0, eresp});
        chk($sformatf("%s_latency", tag), lat, elat);
        chk($sformatf("%s_strobe_len", tag), last_len, elen);
        chk($sformatf("%s_accesses", tag), n_acc - n0, 1);
        if (wr && eresp == 2'b00) ref_write(addr, data, strb);
    endtask

    task automatic contested(input int round);
        int   order[$];
        bit   gr;
        bit   gw;
        tgt_wait    = 0;
        tgt_err     = 1'b0;
        axi.bready  = 1'b1;
        axi.rready  = 1'b1;
        axi.awaddr  = 32'h30;
        axi.wdata   = 32'hCAFE_0000 + round;
        axi.wstrb   = 4'hF;
        axi.araddr  = 32'h24;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.arvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #2;
            gr = axi.arready;
            gw = axi.awready && axi.wready;
            if (gr) order.push_back(1);
            if (gw) order.push_back(0);
            @(posedge aclk);
            #1;
            if (gr) axi.arvalid = 1'b0;
            if (gw) begin
                axi.awvalid = 1'b0;
                axi.wvalid  = 1'b0;
            end
        end
        chk($sformatf("arb%0d_grant_count", round), order.size(), 2);
        if (order.size() == 2) begin
            chk($sformatf("arb%0d_first_is_read", round), order[0], 1);
            chk($sformatf("arb%0d_second_is_write", round), order[1], 0);
        end
        ref_write(32'h30, 32'hCAFE_0000 + round, 4'hF);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          wt;
        bit          err;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          len;
        int          lat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected one by 2ms");
        $fatal(1);
    end

    initial begin
        vec_t        vt[$];
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        int          bad;
        int          n0;

        vt.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0,   1'b0, 2'b00, 32'h0,         1,  2});
        vt.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 0,   1'b0, 2'b00, 32'hDEAD_BEEF, 1,  2});
        vt.push_back('{1'b0, 32'h24, 32'h0,         4'h0, 3,   1'b0, 2'b00, 32'h1234_5678, 4,  5});
        vt.push_back('{1'b1, 32'h10, 32'hAAAA_5555, 4'h3, 1,   1'b0, 2'b00, 32'h0,         2,  3});
        vt.push_back('{1'b0, 32'h10, 32'h0,         4'h0, 2,   1'b0, 2'b00, 32'hDEAD_5555, 3,  4});
        vt.push_back('{1'b1, 32'h14, 32'h1111_1111, 4'hF, 0,   1'b1, 2'b10, 32'h0,         1,  2});
        vt.push_back('{1'b0, 32'h14, 32'h0,         4'h0, 0,   1'b0, 2'b00, 32'h1000_0005, 1,  2});
        vt.push_back('{1'b0, 32'h24, 32'h0,         4'h0, 255, 1'b0, 2'b11, 32'h0,         16, 17});
        vt.push_back('{1'b0, 32'h24, 32'h0,         4'h0, 0,   1'b1, 2'b10, 32'h1234_5678, 1,  2});
        vt.push_back('{1'b0, 32'h18, 32'h0,         4'h0, 15,  1'b0, 2'b00, 32'h1000_0006, 16, 17});
        vt.push_back('{1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 255, 1'b0, 2'b11, 32'h0,         16, 17});
        vt.push_back('{1'b0, 32'h18, 32'h0,         4'h0, 14,  1'b0, 2'b00, 32'h1000_0006, 15, 16});
        vt.push_back('{1'b1, 32'h1C, 32'h00A0_B000, 4'h6, 0,   1'b0, 2'b00, 32'h0,         1,  2});
        vt.push_back('{1'b0, 32'h1C, 32'h0,         4'h0, 0,   1'b0, 2'b00, 32'h10A0_B007, 1,  2});

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + i;
        ref_mem[9] = 32'h1234_5678;

        areset      = 1'b1;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.awprot  = '0;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.bready  = 1'b1;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.arprot  = '0;
        axi.rready  = 1'b1;

        repeat (3) @(posedge aclk);
        #3;
        chk("reset_ctl",
            {25'b0, axi.awready, axi.wready, axi.arready, axi.bvalid,
             axi.rvalid, reg_wr, reg_rd}, 32'h0);
        chk("reset_resp", {28'b0, axi.bresp, axi.rresp}, 32'h0);
        chk("reset_rdata", axi.rdata, 32'h0);
        chk("reset_reg_addr", reg_addr, 32'h0);
        chk("reset_reg_wdata", reg_wdata, 32'h0);
        chk("reset_reg_wstrb", {28'b0, reg_wstrb}, 32'h0);
        tick();
        areset = 1'b0;
        tick();

        contested(0);
        contested(1);

        tgt_wait    = 0;
        tgt_err     = 1'b0;
        axi.awaddr  = 32'h34;
        axi.wdata   = 32'h0BAD_F00D;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b0;
        n0  = n_acc;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (axi.awready || axi.wready || reg_wr) bad++;
            tick();
        end
        chk("aw_only_no_ready", bad, 0);
        chk("aw_only_no_access", n_acc - n0, 0);
        axi.wvalid = 1'b1;
        finish_write(0, resp, lat);
        chk("aw_then_w_resp", {30'b0, resp}, 32'h0);
        chk("aw_then_w_latency", lat, 2);
        chk("aw_then_w_accesses", n_acc - n0, 1);
        ref_write(32'h34, 32'h0BAD_F00D, 4'hF);

        foreach (vt[i])
            run_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].addr,
                    vt[i].data, vt[i].strb, vt[i].wt, vt[i].err,
                    vt[i].resp, vt[i].rdata, vt[i].len, vt[i].lat);

        tgt_wait    = 0;
        tgt_err     = 1'b1;
        axi.araddr  = 32'h20;
        axi.arvalid = 1'b1;
        axi.awaddr  = 32'h38;
        axi.wdata   = 32'h5A5A_5A5A;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        finish_write(5, resp, lat);
        chk("bp_write_resp", {30'b0, resp}, 32'h2);
        #2;
        chk("grant_after_b_handshake", {31'b0, axi.arready}, 32'h1);
        finish_read(resp, rd, lat);
        chk("bp_read_resp", {30'b0, resp}, 32'h2);
        chk("bp_read_rdata", rd, 32'h1000_0008);

        tgt_wait    = 255;
        tgt_err     = 1'b0;
        axi.araddr  = 32'h28;
        axi.arvalid = 1'b1;
        #2;
        chk("rst_seq_grant", {31'b0, axi.arready}, 32'h1);
        tick();
        axi.arvalid = 1'b0;
        tick();
        #2;
        chk("rst_seq_strobe_high", {31'b0, reg_rd}, 32'h1);
        areset = 1'b1;
        #1;
        chk("rst_seq_async_drop", {30'b0, reg_rd, axi.rvalid}, 32'h0);
        chk("rst_seq_addr_clear", reg_addr, 32'h0);
        tick();
        tick();
        areset   = 1'b0;
        tgt_wait = 0;
        #2;
        chk("rst_seq_idle", {29'b0, axi.arready, axi.rvalid, reg_rd}, 32'h0);
        tick();
        run_txn("rst_seq_read", 1'b0, 32'h28, 32'h0, 4'h0, 0, 1'b0,
                2'b00, ref_mem[10], 1, 2);

        for (int t = 0; t < 200; t++) begin
            bit          wr;
            bit          err;
            int          w;
            logic [31:0] addr;
            logic [31:0] data;
            logic [3:0]  strb;
            bit          tmo;
            logic [1:0]  eresp;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 15)) << 2;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            err  = ($urandom_range(0, 7) == 0);
            w    = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 17);
            tmo  = (w > 15);
            eresp = tmo ? 2'b11 : (err ? 2'b10 : 2'b00);
            run_txn($sformatf("rnd%0d", t), wr, addr, data, strb, w, err,
                    eresp, tmo ? 32'h0 : ref_mem[addr[5:2]],
                    tmo ? 16 : w + 1, tmo ? 17 : w + 2);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4_lite_reg_bridge.md
# axi4_lite_reg_bridge

Terminates an AXI4-Lite slave channel set, as delivered by the AXI bus FIFO stage, and converts each transaction into a single-access register bus cycle for a downstream register file or peripheral. Writes and reads are serialized with alternating arbitration, one transaction outstanding at a time. A cycle-count timeout ensures a hung register target always gets a response back on AXI.

## Interface
- A, 32, address width; must match axi4_s.
- N, 4, data bus width in bytes; data is 8*N bits; must match axi4_s.
- TIMEOUT, 16, maximum register access cycles before abort; legal range 2..255.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, asynchronous and active-high.
- axi4_s  axi4_lite_if (slave side)  —  AW/W/AR in, B/R out. awprot/arprot are ignored.
- reg_addr  out  A  captured awaddr or araddr.
- reg_wr  out  1  write strobe, held for the whole access.
- reg_rd  out  1  read strobe, held for the whole access.
- reg_wdata  out  8N  captured wdata.
- reg_wstrb  out  N  captured wstrb.
- reg_rdata  in  8N  read data; valid when reg_ready=1.
- reg_ready  in  1  access complete; sampled every access cycle, including the first.
- reg_err  in  1  target error; qualified by reg_ready.

## Operation
- States: IDLE, WR_ACC, RD_ACC, B_RESP, R_RESP.
- IDLE:
  - A write is pending when awvalid=1 and wvalid=1. AW alone or W alone is never accepted.
  - A read is pending when arvalid=1.
  - With only one kind pending, grant it.
  - With both pending, grant the side not granted last. The last-grant flag resets to "write", so the first contested grant goes to the read.
- Write grant: awready=wready=1 in the same cycle, combinationally from the valids in IDLE. Capture awaddr, wdata and wstrb. Next state WR_ACC.
- Read grant: arready=1, combinationally. Capture araddr. Next state RD_ACC.
- WR_ACC / RD_ACC:
  - The matching strobe is high. A cycle counter clears on entry.
  - On reg_ready=1, capture the response: 2'b10 (SLVERR) if reg_err, else 2'b00. For reads, also capture reg_rdata.
  - Then go to B_RESP or R_RESP.
  - If the counter reaches TIMEOUT-1 with reg_ready=0, abort: response 2'b11 (DECERR), rdata=0, go to the response state. The strobe drops the same edge.
- B_RESP: bvalid=1, bresp = captured response. On bready=1, go to IDLE.
- R_RESP: rvalid=1, rresp and rdata = captured values. On rready=1, go to IDLE.
- All AXI readies are 0 outside IDLE. bresp/rresp/rdata are held stable while valid.
- Reset outputs: awready, wready, arready, bvalid, rvalid, reg_wr, reg_rd all 0. bresp, rresp, rdata, reg_addr, reg_wdata, reg_wstrb all 0. State IDLE, counter 0.
- Reset mid-operation: strobes and valids drop asynchronously and any in-flight response is discarded. Upstream must be reset concurrently.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: strobe asserted.
- Cycle k≥1: reg_ready seen, so bvalid/rvalid assert at cycle k+1.
- Minimum latency from handshake to response valid is 2 cycles. Maximum is TIMEOUT+1.
- Maximum throughput is one transaction per 3 cycles, with immediate reg_ready and bready/rready tied high.
- Strobe duration is exactly until reg_ready, or TIMEOUT cycles. Strobes are never asserted in IDLE or in a response state.
- A new grant may occur in the cycle following the bready/rready handshake, never in the same cycle.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, strb 0xF, reg_ready on the first access cycle:
  - reg_wr is high for exactly 1 cycle with those values.
  - bvalid at cycle 2, bresp=00.
- Single read, addr 0x24, target returns 0x12345678 after 3 wait cycles:
  - reg_rd is high for 4 cycles.
  - rvalid with rdata=0x12345678, rresp=00.
- Contested arbitration: write and read valid together from reset, then again after completion.
  - Order is read, then write.
  - A second simultaneous pair is also served read, then write.
- AW valid without W for 10 cycles: awready stays 0 and no strobe is issued. Asserting wvalid completes the write.
- Timeout, TIMEOUT=16, reg_ready never asserted:
  - reg_rd is high for exactly 16 cycles.
  - rresp=11, rdata=0.
  - reg_err=1 with reg_ready instead gives rresp=10.
- Backpressure and reset:
  - bready held 0 for 5 cycles: bvalid and bresp are stable and no new grant occurs.
  - areset asserted during RD_ACC: reg_rd and rvalid go to 0 immediately, and the bridge is idle after release.
